// File: rtl/addr_window_mapper_if.sv
// Bus bundle for the address window mapper: SNES lookup strobe, MCU shadow-config
// writes, commit/clear controls and the registered lookup result.
interface addr_window_mapper_if #(
  parameter int IW = 3
);
  logic [23:0]   SNES_ADDR;
  logic          ADDR_VALID;
  logic          SNES_WR;
  logic          MCU_WR;
  logic [IW-1:0] MCU_IDX;
  logic [1:0]    MCU_FIELD;
  logic [23:0]   MCU_DATA;
  logic          CFG_COMMIT;
  logic          CLR_STATUS;
  logic [23:0]   ROM_ADDR;
  logic          ROM_HIT;
  logic          IS_WRITABLE;
  logic [IW-1:0] HIT_IDX;
  logic          OUT_VALID;
  logic          CFG_BUSY;
  logic [15:0]   MISS_CNT;
  logic          WR_FAULT;

  modport master (
    output SNES_ADDR, ADDR_VALID, SNES_WR, MCU_WR, MCU_IDX, MCU_FIELD, MCU_DATA,
           CFG_COMMIT, CLR_STATUS,
    input  ROM_ADDR, ROM_HIT, IS_WRITABLE, HIT_IDX, OUT_VALID, CFG_BUSY, MISS_CNT, WR_FAULT
  );

  modport slave (
    input  SNES_ADDR, ADDR_VALID, SNES_WR, MCU_WR, MCU_IDX, MCU_FIELD, MCU_DATA,
           CFG_COMMIT, CLR_STATUS,
    output ROM_ADDR, ROM_HIT, IS_WRITABLE, HIT_IDX, OUT_VALID, CFG_BUSY, MISS_CNT, WR_FAULT
  );
endinterface

// File: rtl/addr_window_mapper.sv
// Maps SNES bus addresses to ROM addresses through N_WIN programmable windows.
// Two-stage lookup; shadow config is copied to active only while the pipe is idle.
module addr_window_mapper #(
  parameter int N_WIN = 8,
  parameter int IW    = 3
) (
  input logic                CLK,
  input logic                nRST,
  addr_window_mapper_if.slave bus
);

  typedef struct packed {
    logic [7:0]  bank_base;
    logic [7:0]  bank_mask;
    logic [3:0]  off_lo;
    logic [3:0]  off_hi;
    logic [23:0] target;
    logic [23:0] amask;
    logic        en;
    logic        wr;
    logic        lorom;
  } win_cfg_t;

  typedef enum logic {IDLE, PEND} state_t;

  win_cfg_t         shadow [N_WIN];
  win_cfg_t         active [N_WIN];
  state_t           state;
  logic             busy;
  logic             apply;

  logic [2:1]       vld_pipe;
  logic [N_WIN-1:0] match;
  logic [N_WIN-1:0] s1_match;
  logic [23:0]      s1_addr;
  logic             s1_wr;

  logic             hit;
  logic [IW-1:0]    win;
  win_cfg_t         wc;
  logic [23:0]      raw;
  logic [23:0]      rom;

  logic [23:0]      rom_addr;
  logic             rom_hit;
  logic             is_wr;
  logic [IW-1:0]    hit_idx;
  logic [15:0]      miss_cnt;
  logic             wr_fault;

  // Per-window match against the active config, evaluated on the raw strobe.
  for (genvar i = 0; i < N_WIN; i++) begin : g_win
    logic [3:0] nib;
    assign nib      = bus.SNES_ADDR[15:12];
    assign match[i] = active[i].en
                   && (((bus.SNES_ADDR[23:16] ^ active[i].bank_base) & active[i].bank_mask) == 8'h00)
                   && (nib >= active[i].off_lo) && (nib <= active[i].off_hi);
  end

  // Lowest index wins; iterate downward so the last assignment is the lowest hit.
  always_comb begin
    hit = 1'b0;
    win = '0;
    wc  = '0;
    for (int i = N_WIN - 1; i >= 0; i--) begin
      if (s1_match[i]) begin
        hit = 1'b1;
        win = IW'(i);
        wc  = active[i];
      end
    end
    raw = wc.lorom ? {1'b0, s1_addr[23:16], s1_addr[14:0]} : s1_addr;
    rom = wc.target + (raw & wc.amask);
  end

  // Applying only with an empty pipe keeps in-flight lookups on their entry config.
  assign apply = (state == PEND) && !bus.ADDR_VALID && (vld_pipe == 2'b00);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.CFG_COMMIT) begin
          state <= PEND;
          busy  <= 1'b1;
        end
        PEND: if (apply) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < N_WIN; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_WIN; i++) begin
        if (apply) active[i] <= shadow[i];
        if (bus.MCU_WR && bus.MCU_IDX == IW'(i)) begin
          case (bus.MCU_FIELD)
            2'd0: begin
              shadow[i].off_hi    <= bus.MCU_DATA[23:20];
              shadow[i].off_lo    <= bus.MCU_DATA[19:16];
              shadow[i].bank_mask <= bus.MCU_DATA[15:8];
              shadow[i].bank_base <= bus.MCU_DATA[7:0];
            end
            2'd1: shadow[i].target <= bus.MCU_DATA;
            2'd2: shadow[i].amask  <= bus.MCU_DATA;
            2'd3: begin
              shadow[i].lorom <= bus.MCU_DATA[2];
              shadow[i].wr    <= bus.MCU_DATA[1];
              shadow[i].en    <= bus.MCU_DATA[0];
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      vld_pipe <= '0;
      s1_match <= '0;
      s1_addr  <= '0;
      s1_wr    <= 1'b0;
      rom_addr <= '0;
      rom_hit  <= 1'b0;
      is_wr    <= 1'b0;
      hit_idx  <= '0;
      miss_cnt <= '0;
      wr_fault <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[1], bus.ADDR_VALID};
      if (bus.ADDR_VALID) begin
        s1_match <= match;
        s1_addr  <= bus.SNES_ADDR;
        s1_wr    <= bus.SNES_WR;
      end
      if (vld_pipe[1]) begin
        rom_hit  <= hit;
        rom_addr <= hit ? rom : 24'h0;
        is_wr    <= hit & wc.wr;
        hit_idx  <= win;
      end
      // Clear takes priority over a miss or fault landing in the same cycle.
      if (bus.CLR_STATUS) begin
        miss_cnt <= '0;
        wr_fault <= 1'b0;
      end else if (vld_pipe[1]) begin
        if (!hit && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
        if (hit && s1_wr && !wc.wr)       wr_fault <= 1'b1;
      end
    end
  end

  assign bus.ROM_ADDR    = rom_addr;
  assign bus.ROM_HIT     = rom_hit;
  assign bus.IS_WRITABLE = is_wr;
  assign bus.HIT_IDX     = hit_idx;
  assign bus.OUT_VALID   = vld_pipe[2];
  assign bus.CFG_BUSY    = busy;
  assign bus.MISS_CNT    = miss_cnt;
  assign bus.WR_FAULT    = wr_fault;

endmodule

// File: tb/tb_addr_window_mapper.sv
// Bench for addr_window_mapper: directed scenarios plus randomized traffic checked
// every cycle against a window-table reference model with a result queue.
module tb_addr_window_mapper;
  localparam int N_WIN = 8;
  localparam int IW    = 3;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  addr_window_mapper_if #(.IW(IW)) bus ();

  addr_window_mapper #(.N_WIN(N_WIN), .IW(IW)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  typedef struct {
    int base, mask, lo, hi, target, amask;
    bit en, wr, lorom;
  } mcfg_t;

  typedef struct {
    int due;
    bit hit;
    int idx;
    int rom;
    bit wrable;
    bit miss;
    bit fault;
  } res_t;

  mcfg_t sh [N_WIN];
  mcfg_t ac [N_WIN];
  res_t  q [$];
  res_t  last;
  int    cyc, last_av, m_cnt;
  bit    m_pend, m_fault;
  int    vectors = 0;
  int    miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic res_t model_lookup(input int addr, input bit w);
    res_t r;
    int bank, nib, raw;
    r = '{default: 0};
    bank = (addr >> 16) & 255;
    nib  = (addr >> 12) & 15;
    for (int i = 0; i < N_WIN; i++) begin
      if (ac[i].en && ((bank ^ ac[i].base) & ac[i].mask) == 0 && nib >= ac[i].lo && nib <= ac[i].hi) begin
        raw = ac[i].lorom ? ((bank << 15) | (addr & 'h7FFF)) : addr;
        r.hit    = 1;
        r.idx    = i;
        r.wrable = ac[i].wr;
        r.rom    = (ac[i].target + (raw & ac[i].amask)) % (1 << 24);
        r.fault  = w && !ac[i].wr;
        return r;
      end
    end
    r.miss = 1;
    return r;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < N_WIN; i++) begin
      sh[i] = '{default: 0};
      ac[i] = '{default: 0};
    end
    q.delete();
    last    = '{default: 0};
    m_pend  = 0;
    m_cnt   = 0;
    m_fault = 0;
    last_av = -100;
  endfunction

  // One clock: advance the model from the current inputs, clock, then check all outputs.
  task automatic tick();
    res_t r;
    bit   apply, exp_ov;
    int   d;
    if (bus.CLR_STATUS) begin
      m_cnt   = 0;
      m_fault = 0;
    end else begin
      foreach (q[j]) if (q[j].due == cyc + 1) begin
        if (q[j].miss && m_cnt < 65535) m_cnt++;
        if (q[j].fault) m_fault = 1;
      end
    end
    if (bus.ADDR_VALID) begin
      r = model_lookup(int'(bus.SNES_ADDR), bus.SNES_WR);
      r.due = cyc + 2;
      q.push_back(r);
    end
    apply = m_pend && !bus.ADDR_VALID && (cyc - last_av >= 3);
    if (bus.ADDR_VALID) last_av = cyc;
    if (apply) begin
      for (int i = 0; i < N_WIN; i++) ac[i] = sh[i];
      m_pend = 0;
    end else if (bus.CFG_COMMIT) begin
      m_pend = 1;
    end
    if (bus.MCU_WR && int'(bus.MCU_IDX) < N_WIN) begin
      d = int'(bus.MCU_DATA);
      case (bus.MCU_FIELD)
        2'd0: begin
          sh[bus.MCU_IDX].base = d & 255;
          sh[bus.MCU_IDX].mask = (d >> 8) & 255;
          sh[bus.MCU_IDX].lo   = (d >> 16) & 15;
          sh[bus.MCU_IDX].hi   = (d >> 20) & 15;
        end
        2'd1: sh[bus.MCU_IDX].target = d;
        2'd2: sh[bus.MCU_IDX].amask  = d;
        default: begin
          sh[bus.MCU_IDX].en    = d[0];
          sh[bus.MCU_IDX].wr    = d[1];
          sh[bus.MCU_IDX].lorom = d[2];
        end
      endcase
    end
    @(posedge CLK);
    #1;
    cyc++;
    exp_ov = 0;
    if (q.size() > 0 && q[0].due == cyc) begin
      last   = q.pop_front();
      exp_ov = 1;
    end
    chk("out_valid",   bus.OUT_VALID,   exp_ov);
    chk("rom_hit",     bus.ROM_HIT,     last.hit);
    chk("rom_addr",    bus.ROM_ADDR,    last.rom);
    chk("is_writable", bus.IS_WRITABLE, last.wrable);
    chk("hit_idx",     bus.HIT_IDX,     last.idx);
    chk("cfg_busy",    bus.CFG_BUSY,    m_pend);
    chk("miss_cnt",    bus.MISS_CNT,    m_cnt);
    chk("wr_fault",    bus.WR_FAULT,    m_fault);
  endtask

  task automatic idle();
    bus.ADDR_VALID = 0; bus.SNES_WR = 0; bus.MCU_WR = 0;
    bus.CFG_COMMIT = 0; bus.CLR_STATUS = 0;
  endtask

  task automatic do_reset();
    idle();
    #2 nRST = 0;
    #1;
    model_clear();
    chk("rst_out_valid", bus.OUT_VALID, 0);
    chk("rst_rom_addr",  bus.ROM_ADDR, 0);
    chk("rst_rom_hit",   bus.ROM_HIT, 0);
    chk("rst_hit_idx",   bus.HIT_IDX, 0);
    chk("rst_is_wr",     bus.IS_WRITABLE, 0);
    chk("rst_busy",      bus.CFG_BUSY, 0);
    chk("rst_miss_cnt",  bus.MISS_CNT, 0);
    chk("rst_wr_fault",  bus.WR_FAULT, 0);
    @(posedge CLK);
    #1 nRST = 1;
  endtask

  task automatic lookup(input logic [23:0] a, input bit w);
    bus.ADDR_VALID = 1; bus.SNES_ADDR = a; bus.SNES_WR = w;
    tick();
    bus.ADDR_VALID = 0; bus.SNES_WR = 0;
  endtask

  task automatic wcfg(input int idx, input int f, input logic [23:0] d);
    bus.MCU_WR = 1; bus.MCU_IDX = IW'(idx); bus.MCU_FIELD = 2'(f); bus.MCU_DATA = d;
    tick();
    bus.MCU_WR = 0;
  endtask

  task automatic setwin(input int idx, input logic [7:0] base, input logic [7:0] mask,
                        input logic [3:0] lo, input logic [3:0] hi, input logic [23:0] target,
                        input logic [23:0] amask, input bit en, input bit wr, input bit lorom);
    wcfg(idx, 0, {hi, lo, mask, base});
    wcfg(idx, 1, target);
    wcfg(idx, 2, amask);
    wcfg(idx, 3, {21'd0, lorom, wr, en});
  endtask

  task automatic commit();
    bus.CFG_COMMIT = 1;
    tick();
    bus.CFG_COMMIT = 0;
    repeat (4) tick();
  endtask

  initial begin
    logic [7:0]  mk, bs;
    logic [23:0] a;
    int          w;
    cyc = 0;
    bus.SNES_ADDR = '0; bus.MCU_IDX = '0; bus.MCU_FIELD = '0; bus.MCU_DATA = '0;
    idle();
    model_clear();
    do_reset();
    repeat (2) tick();

    // Basic HiROM-style window; shadow must not be visible before commit.
    setwin(0, 8'hC0, 8'hC0, 4'h0, 4'hF, 24'h000000, 24'h3FFFFF, 1, 1, 0);
    lookup(24'hC12345, 0); tick();
    chk("pre_commit_hit", bus.ROM_HIT, 0);
    commit();
    lookup(24'hC12345, 0); tick();
    chk("hirom_hit", bus.ROM_HIT, 1);
    chk("hirom_addr", bus.ROM_ADDR, 24'h012345);
    chk("hirom_idx", bus.HIT_IDX, 0);
    tick();

    // LoROM fold.
    setwin(1, 8'h00, 8'h80, 4'h8, 4'hF, 24'h100000, 24'h0FFFFF, 1, 1, 1);
    commit();
    lookup(24'h018123, 0); tick();
    chk("lorom_addr", bus.ROM_ADDR, 24'h108123);
    chk("lorom_idx", bus.HIT_IDX, 1);

    // Overlap priority and write fault.
    setwin(0, 8'h70, 8'hFF, 4'h0, 4'hF, 24'h000000, 24'hFFFFFF, 1, 0, 0);
    setwin(2, 8'h70, 8'hF0, 4'h0, 4'hF, 24'h000000, 24'hFFFFFF, 1, 1, 0);
    commit();
    lookup(24'h700000, 1); tick();
    chk("prio_idx", bus.HIT_IDX, 0);
    chk("prio_is_wr", bus.IS_WRITABLE, 0);
    chk("prio_fault", bus.WR_FAULT, 1);
    bus.CLR_STATUS = 1; tick(); bus.CLR_STATUS = 0;
    chk("clr_fault", bus.WR_FAULT, 0);

    // Commit alongside back-to-back strobes; second commit absorbed; write during PEND applied.
    bus.CFG_COMMIT = 1;
    lookup(24'h700000, 0);
    lookup(24'h700000, 0);
    bus.CFG_COMMIT = 0;
    wcfg(0, 1, 24'h200000);
    chk("busy_during", bus.CFG_BUSY, 1);
    tick();
    chk("busy_last", bus.CFG_BUSY, 1);
    tick();
    chk("busy_clear", bus.CFG_BUSY, 0);
    lookup(24'h700000, 0); tick();
    chk("new_cfg_addr", bus.ROM_ADDR, 24'h900000);

    // Address wrap.
    setwin(4, 8'h40, 8'hFF, 4'h0, 4'hF, 24'hFFFF00, 24'h00FFFF, 1, 1, 0);
    commit();
    lookup(24'h400200, 0); tick();
    chk("wrap_addr", bus.ROM_ADDR, 24'h000100);
    chk("wrap_idx", bus.HIT_IDX, 4);

    // Randomized windows and traffic.
    for (int i = 0; i < N_WIN; i++) begin
      mk = 8'(8'hFF << $urandom_range(0, 8));
      bs = 8'($urandom);
      wcfg(i, 0, {4'($urandom), 4'($urandom), mk, bs});
      wcfg(i, 1, 24'($urandom));
      wcfg(i, 2, 24'hFFFFFF >> $urandom_range(0, 12));
      wcfg(i, 3, {21'd0, 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0)});
    end
    commit();
    for (int n = 0; n < 600; n++) begin
      w = $urandom_range(0, N_WIN - 1);
      a = 24'($urandom);
      if ($urandom_range(0, 1) == 1) a[23:16] = 8'(sh[w].base) ^ (8'($urandom) & ~8'(sh[w].mask));
      bus.SNES_ADDR  = a;
      bus.SNES_WR    = 1'($urandom);
      bus.ADDR_VALID = ((n / 16) % 3 != 2) ? 1'($urandom_range(0, 3) != 0) : 1'b0;
      bus.CFG_COMMIT = ($urandom_range(0, 19) == 0);
      bus.CLR_STATUS = ($urandom_range(0, 29) == 0);
      bus.MCU_WR     = ($urandom_range(0, 9) == 0);
      bus.MCU_IDX    = IW'($urandom);
      bus.MCU_FIELD  = 2'($urandom);
      bus.MCU_DATA   = 24'($urandom);
      tick();
    end
    idle();
    repeat (6) tick();

    // Reset while a lookup is in flight, and while a commit is pending.
    lookup(24'h400200, 0);
    do_reset();
    repeat (3) tick();
    chk("no_ov_after_rst", bus.OUT_VALID, 0);
    bus.CFG_COMMIT = 1;
    lookup(24'h123456, 0);
    bus.CFG_COMMIT = 0;
    do_reset();
    repeat (4) tick();
    chk("busy_after_rst", bus.CFG_BUSY, 0);

    // Saturating miss counter (all windows disabled after reset).
    bus.ADDR_VALID = 1;
    for (int n = 0; n < 65537; n++) begin
      bus.SNES_ADDR = 24'($urandom);
      tick();
    end
    idle();
    repeat (2) tick();
    chk("miss_sat", bus.MISS_CNT, 16'hFFFF);
    lookup(24'h000000, 0);
    bus.CLR_STATUS = 1; tick(); bus.CLR_STATUS = 0;
    chk("clr_vs_miss", bus.MISS_CNT, 0);
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
